// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
//   Pipelined control unit. Decodes the ID-stage opcode into a 15-bit control
//   bundle and carries it through the ID/EX, EX/MEM and MEM/WB registers. It
//   stalls on load-use hazards and on multi-cycle MUL, and flushes IF/ID when
//   a branch or jump resolved in EX redirects the PC.
//
//   Bundle [14:0] = {aluop[3:0], wen, memread, memwrite, branch, alusrc,
//                    memtoreg, regdst, jump, jr, jal, mul}
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   id_valid                  IF/ID holds a real instruction
//   id_opcode/rs/rt/rd        ID-stage opcode and register fields
//   ex_redirect               datapath reports a taken branch/jump in EX
//   stall, flush              combinational: hold PC + IF/ID, kill IF/ID
//   ex_/mem_/wb_valid,ctrl,dst registered stage contents
//   illegal                   registered 1-cycle pulse when an undefined
//                             opcode moves from ID into EX
//
// Opcode encodings:
//   ADD=0 SUB=1 AND=2 XOR=3 COM=4 MUL=5 SLL=6 SRL=7
//   LW=8  SW=9  BEQ=10 J=11 JR=12 JAL=13; 14 and 15 are undefined.

module pipe_ctrl_unit #(
    parameter int OPW     = 4,
    parameter int RAW     = 5,
    parameter int MUL_LAT = 3,
    parameter int HAZ_EN  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [OPW-1:0] id_opcode,
    input  logic [RAW-1:0] id_rs,
    input  logic [RAW-1:0] id_rt,
    input  logic [RAW-1:0] id_rd,
    input  logic           ex_redirect,
    output logic           stall,
    output logic           flush,
    output logic           ex_valid,
    output logic [14:0]    ex_ctrl,
    output logic [RAW-1:0] ex_dst,
    output logic           mem_valid,
    output logic [14:0]    mem_ctrl,
    output logic [RAW-1:0] mem_dst,
    output logic           wb_valid,
    output logic [14:0]    wb_ctrl,
    output logic [RAW-1:0] wb_dst,
    output logic           illegal
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR = OPW'(3);
    localparam logic [OPW-1:0] OP_COM = OPW'(4);
    localparam logic [OPW-1:0] OP_MUL = OPW'(5);
    localparam logic [OPW-1:0] OP_SLL = OPW'(6);
    localparam logic [OPW-1:0] OP_SRL = OPW'(7);
    localparam logic [OPW-1:0] OP_LW  = OPW'(8);
    localparam logic [OPW-1:0] OP_SW  = OPW'(9);
    localparam logic [OPW-1:0] OP_BEQ = OPW'(10);
    localparam logic [OPW-1:0] OP_J   = OPW'(11);
    localparam logic [OPW-1:0] OP_JR  = OPW'(12);
    localparam logic [OPW-1:0] OP_JAL = OPW'(13);

    localparam int B_WEN      = 10;
    localparam int B_MEMREAD  = 9;
    localparam int B_MEMWRITE = 8;
    localparam int B_BRANCH   = 7;
    localparam int B_ALUSRC   = 6;
    localparam int B_MEMTOREG = 5;
    localparam int B_REGDST   = 4;
    localparam int B_JUMP     = 3;
    localparam int B_JR       = 2;
    localparam int B_JAL      = 1;
    localparam int B_MUL      = 0;

    // Counter value loaded when MUL enters EX: number of extra EX cycles.
    localparam logic [3:0] MUL_INIT = 4'(MUL_LAT - 1);

    // Stage registers
    logic           ex_valid_q,  ex_valid_d;
    logic [14:0]    ex_ctrl_q,   ex_ctrl_d;
    logic [RAW-1:0] ex_dst_q,    ex_dst_d;
    logic           mem_valid_q, mem_valid_d;
    logic [14:0]    mem_ctrl_q,  mem_ctrl_d;
    logic [RAW-1:0] mem_dst_q,   mem_dst_d;
    logic           wb_valid_q,  wb_valid_d;
    logic [14:0]    wb_ctrl_q,   wb_ctrl_d;
    logic [RAW-1:0] wb_dst_q,    wb_dst_d;
    logic           illegal_q,   illegal_d;
    logic [3:0]     mul_cnt_q,   mul_cnt_d;

    // Decoder results
    logic [3:0]     dec_aluop;
    logic [14:0]    dec_ctrl;
    logic [RAW-1:0] dec_dst;
    logic           dec_legal;
    logic           dec_reads_rt;

    // Hazard signals
    logic mul_busy;
    logic redirect;
    logic load_use;
    logic stall_c;
    logic flush_c;

    // aluop is the opcode truncated or zero-extended to 4 bits.
    if (OPW >= 4) begin : g_aluop_trunc
        assign dec_aluop = id_opcode[3:0];
    end else begin : g_aluop_ext
        assign dec_aluop = {{(4-OPW){1'b0}}, id_opcode};
    end

    // Decoder: opcode to control bundle and destination register.
    always_comb begin
        dec_ctrl     = '0;
        dec_dst      = '0;
        dec_legal    = 1'b1;
        dec_reads_rt = 1'b0;
        case (id_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_COM: begin
                dec_ctrl[B_WEN]      = 1'b1;
                dec_ctrl[B_MEMTOREG] = 1'b1;
                dec_dst              = id_rd;
                dec_reads_rt         = 1'b1;
            end
            OP_MUL: begin
                dec_ctrl[B_WEN]      = 1'b1;
                dec_ctrl[B_MEMTOREG] = 1'b1;
                dec_ctrl[B_MUL]      = 1'b1;
                dec_dst              = id_rd;
                dec_reads_rt         = 1'b1;
            end
            OP_SLL, OP_SRL: begin
                dec_ctrl[B_WEN]      = 1'b1;
                dec_ctrl[B_ALUSRC]   = 1'b1;
                dec_ctrl[B_MEMTOREG] = 1'b1;
                dec_dst              = id_rt;
            end
            OP_LW: begin
                dec_ctrl[B_WEN]      = 1'b1;
                dec_ctrl[B_ALUSRC]   = 1'b1;
                dec_ctrl[B_MEMREAD]  = 1'b1;
                dec_dst              = id_rt;
            end
            OP_SW: begin
                dec_ctrl[B_ALUSRC]   = 1'b1;
                dec_ctrl[B_MEMWRITE] = 1'b1;
                dec_ctrl[B_MEMTOREG] = 1'b1;
                dec_ctrl[B_REGDST]   = 1'b1;
                dec_reads_rt         = 1'b1;
            end
            OP_BEQ: begin
                dec_ctrl[B_BRANCH]   = 1'b1;
                dec_ctrl[B_MEMTOREG] = 1'b1;
                dec_ctrl[B_REGDST]   = 1'b1;
                dec_reads_rt         = 1'b1;
            end
            OP_J: begin
                dec_ctrl[B_BRANCH]   = 1'b1;
                dec_ctrl[B_MEMTOREG] = 1'b1;
                dec_ctrl[B_JUMP]     = 1'b1;
            end
            OP_JR: begin
                dec_ctrl[B_BRANCH]   = 1'b1;
                dec_ctrl[B_MEMTOREG] = 1'b1;
                dec_ctrl[B_JR]       = 1'b1;
            end
            OP_JAL: begin
                dec_ctrl[B_BRANCH]   = 1'b1;
                dec_ctrl[B_MEMTOREG] = 1'b1;
                dec_ctrl[B_JAL]      = 1'b1;
                dec_ctrl[B_WEN]      = 1'b1;
                dec_dst              = '1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase
        // Undefined opcodes leave the whole bundle zero, including aluop.
        if (dec_legal) begin
            dec_ctrl[14:11] = dec_aluop;
        end
        // Writes to register 0 are never enabled.
        if (dec_dst == '0) begin
            dec_ctrl[B_WEN] = 1'b0;
        end
    end

    // Hazard detection. A busy MUL outranks a redirect, which outranks load-use;
    // reset forces both outputs low.
    always_comb begin
        mul_busy = (mul_cnt_q != 4'd0);
        redirect = ex_redirect & ex_valid_q & ex_ctrl_q[B_BRANCH];
        load_use = (HAZ_EN != 0) & id_valid & ex_valid_q & ex_ctrl_q[B_MEMREAD]
                 & (ex_dst_q != '0)
                 & ((ex_dst_q == id_rs) | ((ex_dst_q == id_rt) & dec_reads_rt));
        stall_c  = ~rst & (mul_busy | (load_use & ~redirect));
        flush_c  = ~rst & redirect & ~mul_busy;
    end

    // Pipeline advance. While MUL is busy, EX holds and MEM receives bubbles;
    // otherwise everything moves forward and ID enters EX unless stalled or
    // flushed, in which case EX receives a bubble.
    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_ctrl_d   = ex_ctrl_q;
        ex_dst_d    = ex_dst_q;
        mem_valid_d = ex_valid_q;
        mem_ctrl_d  = ex_ctrl_q;
        mem_dst_d   = ex_dst_q;
        wb_valid_d  = mem_valid_q;
        wb_ctrl_d   = mem_ctrl_q;
        wb_dst_d    = mem_dst_q;
        illegal_d   = 1'b0;
        mul_cnt_d   = mul_cnt_q;

        if (mul_busy) begin
            mem_valid_d = 1'b0;
            mem_ctrl_d  = '0;
            mem_dst_d   = '0;
            mul_cnt_d   = mul_cnt_q - 4'd1;
        end else if (stall_c | flush_c | ~id_valid) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            ex_dst_d   = '0;
        end else begin
            ex_valid_d = 1'b1;
            ex_ctrl_d  = dec_ctrl;
            ex_dst_d   = dec_dst;
            illegal_d  = ~dec_legal;
            if (dec_ctrl[B_MUL]) begin
                mul_cnt_d = MUL_INIT;
            end
        end

        // Reset clears every stage and aborts any MUL in progress.
        if (rst) begin
            ex_valid_d  = 1'b0;
            ex_ctrl_d   = '0;
            ex_dst_d    = '0;
            mem_valid_d = 1'b0;
            mem_ctrl_d  = '0;
            mem_dst_d   = '0;
            wb_valid_d  = 1'b0;
            wb_ctrl_d   = '0;
            wb_dst_d    = '0;
            illegal_d   = 1'b0;
            mul_cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        ex_valid_q  <= ex_valid_d;
        ex_ctrl_q   <= ex_ctrl_d;
        ex_dst_q    <= ex_dst_d;
        mem_valid_q <= mem_valid_d;
        mem_ctrl_q  <= mem_ctrl_d;
        mem_dst_q   <= mem_dst_d;
        wb_valid_q  <= wb_valid_d;
        wb_ctrl_q   <= wb_ctrl_d;
        wb_dst_q    <= wb_dst_d;
        illegal_q   <= illegal_d;
        mul_cnt_q   <= mul_cnt_d;
    end

    assign stall     = stall_c;
    assign flush     = flush_c;
    assign ex_valid  = ex_valid_q;
    assign ex_ctrl   = ex_ctrl_q;
    assign ex_dst    = ex_dst_q;
    assign mem_valid = mem_valid_q;
    assign mem_ctrl  = mem_ctrl_q;
    assign mem_dst   = mem_dst_q;
    assign wb_valid  = wb_valid_q;
    assign wb_ctrl   = wb_ctrl_q;
    assign wb_dst    = wb_dst_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit
//   Drives two instances of pipe_ctrl_unit from the same ID stream:
//   dut_a (HAZ_EN=1, MUL_LAT=3) and dut_b (HAZ_EN=0, MUL_LAT=1).
//   Every cycle both are compared against a reference model that describes
//   the decoder as per-field equations over instruction classes and the
//   pipeline as stage contents plus "cycles spent in EX" for MUL.

module tb_pipe_ctrl_unit;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    localparam int OP_ADD = 0,  OP_MUL = 5,  OP_SLL = 6,  OP_SRL = 7;
    localparam int OP_LW  = 8,  OP_SW  = 9,  OP_BEQ = 10, OP_J   = 11;
    localparam int OP_JR  = 12, OP_JAL = 13, OP_BAD = 14;

    typedef struct packed {
        logic        ev;
        logic [14:0] ec;
        logic [4:0]  ed;
        logic        mv;
        logic [14:0] mc;
        logic [4:0]  md;
        logic        wv;
        logic [14:0] wc;
        logic [4:0]  wd;
        logic        ill;
    } pipe_t;

    typedef struct packed {
        pipe_t      p;
        logic [7:0] age;
    } mstate_t;

    typedef struct packed {
        logic        legal;
        logic        reads_rt;
        logic [14:0] ctrl;
        logic [4:0]  dst;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_opcode;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_redirect;

    logic        a_stall, a_flush, a_ex_valid, a_mem_valid, a_wb_valid, a_illegal;
    logic [14:0] a_ex_ctrl, a_mem_ctrl, a_wb_ctrl;
    logic [4:0]  a_ex_dst, a_mem_dst, a_wb_dst;
    logic        b_stall, b_flush, b_ex_valid, b_mem_valid, b_wb_valid, b_illegal;
    logic [14:0] b_ex_ctrl, b_mem_ctrl, b_wb_ctrl;
    logic [4:0]  b_ex_dst, b_mem_dst, b_wb_dst;

    pipe_t   obsA, obsB;
    mstate_t ma, mb;
    int      compared, mismatched;
    bit      checking;
    logic    seenStallA, seenStallB, seenFlushA, expStallA;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.OPW(4), .RAW(5), .MUL_LAT(LAT_A), .HAZ_EN(1)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(a_stall), .flush(a_flush),
        .ex_valid(a_ex_valid), .ex_ctrl(a_ex_ctrl), .ex_dst(a_ex_dst),
        .mem_valid(a_mem_valid), .mem_ctrl(a_mem_ctrl), .mem_dst(a_mem_dst),
        .wb_valid(a_wb_valid), .wb_ctrl(a_wb_ctrl), .wb_dst(a_wb_dst),
        .illegal(a_illegal)
    );

    pipe_ctrl_unit #(.OPW(4), .RAW(5), .MUL_LAT(LAT_B), .HAZ_EN(0)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_redirect(ex_redirect),
        .stall(b_stall), .flush(b_flush),
        .ex_valid(b_ex_valid), .ex_ctrl(b_ex_ctrl), .ex_dst(b_ex_dst),
        .mem_valid(b_mem_valid), .mem_ctrl(b_mem_ctrl), .mem_dst(b_mem_dst),
        .wb_valid(b_wb_valid), .wb_ctrl(b_wb_ctrl), .wb_dst(b_wb_dst),
        .illegal(b_illegal)
    );

    assign obsA = {a_ex_valid, a_ex_ctrl, a_ex_dst, a_mem_valid, a_mem_ctrl, a_mem_dst,
                   a_wb_valid, a_wb_ctrl, a_wb_dst, a_illegal};
    assign obsB = {b_ex_valid, b_ex_ctrl, b_ex_dst, b_mem_valid, b_mem_ctrl, b_mem_dst,
                   b_wb_valid, b_wb_ctrl, b_wb_dst, b_illegal};

    // Decoder reference: each bundle field as an equation over instruction classes.
    function automatic dec_t modelDecode(logic [3:0] op, logic [4:0] rt, logic [4:0] rd);
        dec_t r;
        int   o;
        bit   isR, isShift, isLw, isSw, isBeq, isJmp, isJal, wen;
        o       = int'(op);
        isR     = (o <= OP_MUL);
        isShift = (o == OP_SLL) || (o == OP_SRL);
        isLw    = (o == OP_LW);
        isSw    = (o == OP_SW);
        isBeq   = (o == OP_BEQ);
        isJmp   = (o >= OP_J) && (o <= OP_JAL);
        isJal   = (o == OP_JAL);
        r       = '0;
        r.legal    = (o <= OP_JAL);
        r.reads_rt = isR || isSw || isBeq;
        r.dst      = isR ? rd : (isShift || isLw) ? rt : isJal ? 5'd31 : 5'd0;
        wen        = (isR || isShift || isLw || isJal) && (r.dst != 5'd0);
        if (r.legal)
            r.ctrl = {op, wen, isLw, isSw, isBeq || isJmp, isShift || isLw || isSw,
                      isR || isShift || isSw || isBeq || isJmp, isSw || isBeq,
                      o == OP_J, o == OP_JR, isJal, o == OP_MUL};
        return r;
    endfunction

    // MUL occupies EX for lat cycles in total; it is busy until its last one.
    function automatic bit mulBusy(mstate_t m, int lat);
        return m.p.ev && m.p.ec[0] && (int'(m.age) < lat);
    endfunction

    // Returns {stall, flush} for the current state and ID inputs.
    function automatic logic [1:0] modelComb(mstate_t m, int lat, bit haz, logic r, logic v,
                                             logic [3:0] op, logic [4:0] rs, logic [4:0] rt,
                                             logic [4:0] rd, logic redir);
        dec_t d;
        bit   busy, redirect, lu;
        if (r) return 2'b00;
        d        = modelDecode(op, rt, rd);
        busy     = mulBusy(m, lat);
        redirect = redir && m.p.ev && m.p.ec[7];
        lu       = haz && v && m.p.ev && m.p.ec[9] && (m.p.ed != 5'd0) &&
                   ((m.p.ed == rs) || ((m.p.ed == rt) && d.reads_rt));
        return {busy || (lu && !redirect), redirect && !busy};
    endfunction

    function automatic mstate_t modelStep(mstate_t m, int lat, bit haz, logic r, logic v,
                                          logic [3:0] op, logic [4:0] rs, logic [4:0] rt,
                                          logic [4:0] rd, logic redir);
        mstate_t    n;
        dec_t       d;
        logic [1:0] c;
        if (r) return '0;
        d = modelDecode(op, rt, rd);
        c = modelComb(m, lat, haz, r, v, op, rs, rt, rd, redir);
        n = m;
        n.p.ill = 1'b0;
        n.p.wv = m.p.mv;  n.p.wc = m.p.mc;  n.p.wd = m.p.md;
        if (mulBusy(m, lat)) begin
            n.p.mv = 1'b0;  n.p.mc = '0;  n.p.md = '0;
            n.age  = m.age + 8'd1;
        end else begin
            n.p.mv = m.p.ev;  n.p.mc = m.p.ec;  n.p.md = m.p.ed;
            if (c[1] || c[0] || !v) begin
                n.p.ev = 1'b0;  n.p.ec = '0;  n.p.ed = '0;
            end else begin
                n.p.ev  = 1'b1;  n.p.ec = d.ctrl;  n.p.ed = d.dst;
                n.p.ill = !d.legal;
                n.age   = 8'd1;
            end
        end
        return n;
    endfunction

    // Single comparison point: counts and reports one check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkDut(input string who, input pipe_t o, input pipe_t e,
                            input logic st, input logic fl, input logic [1:0] c);
        checkOutput({who, "_stall"},     32'(st),   32'(c[1]));
        checkOutput({who, "_flush"},     32'(fl),   32'(c[0]));
        checkOutput({who, "_ex_valid"},  32'(o.ev), 32'(e.ev));
        checkOutput({who, "_ex_ctrl"},   32'(o.ec), 32'(e.ec));
        checkOutput({who, "_ex_dst"},    32'(o.ed), 32'(e.ed));
        checkOutput({who, "_mem_valid"}, 32'(o.mv), 32'(e.mv));
        checkOutput({who, "_mem_ctrl"},  32'(o.mc), 32'(e.mc));
        checkOutput({who, "_mem_dst"},   32'(o.md), 32'(e.md));
        checkOutput({who, "_wb_valid"},  32'(o.wv), 32'(e.wv));
        checkOutput({who, "_wb_ctrl"},   32'(o.wc), 32'(e.wc));
        checkOutput({who, "_wb_dst"},    32'(o.wd), 32'(e.wd));
        checkOutput({who, "_illegal"},   32'(o.ill), 32'(e.ill));
    endtask

    // One clock cycle: drive ID inputs, check both DUTs mid-cycle, advance models.
    task automatic applyStimulus(input logic r, input logic v, input int op,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic redir);
        logic [1:0] ca, cb;
        mstate_t    na, nb;
        rst = r;  id_valid = v;  id_opcode = 4'(op);
        id_rs = rs;  id_rt = rt;  id_rd = rd;  ex_redirect = redir;
        @(negedge clk);
        ca = modelComb(ma, LAT_A, 1'b1, r, v, id_opcode, rs, rt, rd, redir);
        cb = modelComb(mb, LAT_B, 1'b0, r, v, id_opcode, rs, rt, rd, redir);
        if (checking) begin
            checkDut("a", obsA, ma.p, a_stall, a_flush, ca);
            checkDut("b", obsB, mb.p, b_stall, b_flush, cb);
        end
        seenStallA = a_stall;
        seenStallB = b_stall;
        seenFlushA = a_flush;
        expStallA  = ca[1];
        na = modelStep(ma, LAT_A, 1'b1, r, v, id_opcode, rs, rt, rd, redir);
        nb = modelStep(mb, LAT_B, 1'b0, r, v, id_opcode, rs, rt, rd, redir);
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0);
    endtask

    initial begin
        logic       rv, vv, redv;
        logic [3:0] opv;
        logic [4:0] rsv, rtv, rdv;
        logic       expStall3 [3];

        compared = 0;  mismatched = 0;  checking = 1'b0;
        ma = '0;  mb = '0;
        expStallA = 1'b0;

        // Reset for two cycles, then check the cleared state
        applyStimulus(1'b1, 1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 1'b0);
        checking = 1'b1;
        checkOutput("rst_ex_valid",  32'(a_ex_valid),  0);
        checkOutput("rst_wb_valid",  32'(a_wb_valid),  0);
        checkOutput("rst_mem_ctrl",  32'(a_mem_ctrl),  0);

        // ADD r3 <- r1, r2: EX after 1 cycle, WB after 3
        applyStimulus(1'b0, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        checkOutput("t1_ex_valid", 32'(a_ex_valid), 1);
        checkOutput("t1_ex_dst",   32'(a_ex_dst),   3);
        checkOutput("t1_ex_wen",   32'(a_ex_ctrl[10]), 1);
        checkOutput("t1_ex_ctrl",  32'(a_ex_ctrl),  32'h0420);
        idle(2);
        checkOutput("t1_wb_valid", 32'(a_wb_valid), 1);
        checkOutput("t1_wb_dst",   32'(a_wb_dst),   3);

        // LW r5 then ADD using r5: one stall with hazard detection, none without
        applyStimulus(1'b0, 1'b1, OP_LW, 5'd1, 5'd5, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_ADD, 5'd5, 5'd2, 5'd6, 1'b0);
        checkOutput("t2_stall_a", 32'(seenStallA), 1);
        checkOutput("t2_stall_b", 32'(seenStallB), 0);
        checkOutput("t2_bubble",  32'(a_ex_valid), 0);
        applyStimulus(1'b0, 1'b1, OP_ADD, 5'd5, 5'd2, 5'd6, 1'b0);
        checkOutput("t2_stall_drop", 32'(seenStallA), 0);
        checkOutput("t2_add_ex",     32'(a_ex_dst),   6);

        // MUL then ADD: stall 2 cycles, MEM gets 2 bubbles, ADD in EX afterwards
        idle(3);
        applyStimulus(1'b0, 1'b1, OP_MUL, 5'd1, 5'd2, 5'd4, 1'b0);
        expStall3 = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd7, 1'b0);
            checkOutput($sformatf("t3_stall%0d", k), 32'(seenStallA), 32'(expStall3[k]));
            checkOutput($sformatf("t3_mem_valid%0d", k), 32'(a_mem_valid), 32'(k == 2));
        end
        checkOutput("t3_mem_mul", 32'(a_mem_ctrl[0]), 1);
        checkOutput("t3_add_ex",  32'(a_ex_dst), 7);

        // BEQ redirect: flush, no stall, ID becomes a bubble, branch to MEM
        idle(3);
        applyStimulus(1'b0, 1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b1);
        checkOutput("t4_flush",    32'(seenFlushA), 1);
        checkOutput("t4_stall",    32'(seenStallA), 0);
        checkOutput("t4_ex_valid", 32'(a_ex_valid), 0);
        checkOutput("t4_mem_br",   32'(a_mem_ctrl[7]), 1);
        // Redirect with a non-branch in EX is ignored
        applyStimulus(1'b0, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd3, 1'b0);
        applyStimulus(1'b0, 1'b0, OP_ADD, 5'd0, 5'd0, 5'd0, 1'b1);
        checkOutput("t4_unqual_flush", 32'(seenFlushA), 0);

        // Undefined opcode, then JAL
        applyStimulus(1'b0, 1'b1, OP_BAD, 5'd1, 5'd2, 5'd3, 1'b0);
        checkOutput("t5_ill",      32'(a_illegal),  1);
        checkOutput("t5_ex_valid", 32'(a_ex_valid), 1);
        checkOutput("t5_ex_ctrl",  32'(a_ex_ctrl),  0);
        applyStimulus(1'b0, 1'b1, OP_JAL, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("t5_ill_drop", 32'(a_illegal),     0);
        checkOutput("t5_jal_dst",  32'(a_ex_dst),      31);
        checkOutput("t5_jal_wen",  32'(a_ex_ctrl[10]), 1);
        checkOutput("t5_jal_bit",  32'(a_ex_ctrl[1]),  1);

        // Reset in the middle of a MUL
        idle(3);
        applyStimulus(1'b0, 1'b1, OP_MUL, 5'd1, 5'd2, 5'd4, 1'b0);
        applyStimulus(1'b0, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd5, 1'b0);
        applyStimulus(1'b1, 1'b1, OP_ADD, 5'd1, 5'd2, 5'd5, 1'b0);
        checkOutput("t6_ex_valid",  32'(a_ex_valid),  0);
        checkOutput("t6_mem_valid", 32'(a_mem_valid), 0);
        checkOutput("t6_wb_valid",  32'(a_wb_valid),  0);
        idle(1);
        checkOutput("t6_stall", 32'(seenStallA), 0);

        // Randomized traffic; a stalled instruction is held in ID like a real IF/ID
        opv = 4'd0;  rsv = 5'd0;  rtv = 5'd0;  rdv = 5'd0;  vv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!expStallA) begin
                vv  = ($urandom_range(0, 9) != 0);
                opv = 4'($urandom_range(0, 15));
                rsv = 5'($urandom_range(0, 3));
                rtv = 5'($urandom_range(0, 3));
                rdv = 5'($urandom_range(0, 3));
            end
            redv = ($urandom_range(0, 2) == 0);
            rv   = ($urandom_range(0, 149) == 0);
            applyStimulus(rv, vv, int'(opv), rsv, rtv, rdv, redv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
